// File: rtl/spi_pkg.sv
// spi_pkg
// Shared definitions for the host-side SPI master and the peripheral SPI
// slave: message-type codes, maximum frame width, the master FSM state type
// and the frame-length decode used by both ends of the link.
package spi_pkg;

    localparam int unsigned MAX_BITS = 48;

    localparam logic [2:0] NO_BY      = 3'b000;
    localparam logic [2:0] ONE_BY     = 3'b001;
    localparam logic [2:0] STD_TWO_BY = 3'b010;
    localparam logic [2:0] THREE_BY   = 3'b011;
    localparam logic [2:0] SIX_BY     = 3'b110;
    localparam logic [2:0] LONG       = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_e;

    // Frame length in bits. LONG takes its length from byte_count, with 0
    // treated as a two-byte frame and anything above 6 clamped to 48 bits.
    function automatic logic [5:0] frame_bits(input logic [2:0] msg,
                                              input logic [3:0] count);
        logic [5:0] n;
        case (msg)
            ONE_BY:     n = 6'd8;
            STD_TWO_BY: n = 6'd16;
            THREE_BY:   n = 6'd24;
            SIX_BY:     n = 6'd48;
            LONG: begin
                if (count == 4'd0)
                    n = 6'd16;
                else if (count > 4'd6)
                    n = 6'd48;
                else
                    n = {count[2:0], 3'b000};
            end
            default:    n = 6'd16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// spi_half_period_timer
// Down-counter that times SCK half periods, the CSEL lead-in and the CSEL
// gap. A load of L makes expire pulse for one cycle L cycles later (the
// cycle in which the count reads 1); after that the counter rests at zero.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value (wins over counting)
//   load_value  : cycles until expire, must be >= 1
//   expire      : one-cycle pulse at the end of the loaded period
module spi_half_period_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (count != '0)
            count <= count - WIDTH'(1);
    end

    assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
// Host-side SPI master. Runs one full-duplex, MSB-first frame of 8..48 bits
// per accepted start, with a CSEL lead-in before the first SCK rise and a
// CSEL-high gap before busy drops.
// Ports:
//   CLK, RST    : system clock, asynchronous active-low reset
//   start       : frame request, only honoured while idle
//   msg_type    : frame length code (see spi_pkg::frame_bits)
//   byte_count  : byte count for LONG frames
//   tx_data     : frame data, right-aligned, bit N-1 sent first
//   busy        : accept cycle through end of CSEL gap
//   done        : one-cycle pulse, rx_data valid
//   rx_data     : last received frame, right-aligned, zero-extended
//   SCK, MOSI   : serial clock (idles low) and master data out
//   CSEL        : chip select, active low
//   MISO        : slave data in, asynchronous to CLK
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 8,
    parameter int unsigned CS_LEAD = 8,
    parameter int unsigned CS_GAP  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [2:0]          msg_type,
    input  logic [3:0]          byte_count,
    input  logic [MAX_BITS-1:0] tx_data,
    output logic                busy,
    output logic                done,
    output logic [MAX_BITS-1:0] rx_data,
    output logic                SCK,
    output logic                MOSI,
    output logic                CSEL,
    input  logic                MISO
);

    localparam int unsigned TW = 16;

    state_e              state, state_nxt;
    logic [5:0]          n_frame;
    logic [MAX_BITS-1:0] tx_aligned;
    logic [MAX_BITS-1:0] shift_tx;
    logic [MAX_BITS-1:0] shift_rx;
    logic [5:0]          bit_cnt;
    logic                miso_s1, miso_s2;

    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_expire;

    logic                do_accept, do_rise_first, do_fall, do_rise_next;
    logic                do_finish, do_gap_end;

    assign n_frame    = frame_bits(msg_type, byte_count);
    // Left-justify so the frame MSB sits at bit 47; bits above N fall off.
    assign tx_aligned = tx_data << (6'(MAX_BITS) - n_frame);
    // MOSI is the top of the transmit shifter; clearing the shifter at the
    // end of a frame returns MOSI to 0.
    assign MOSI       = shift_tx[MAX_BITS-1];

    spi_half_period_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk        (CLK),
        .rst_n      (RST),
        .load       (tmr_load),
        .load_value (tmr_val),
        .expire     (tmr_expire)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        tmr_load      = 1'b0;
        tmr_val       = '0;
        do_accept     = 1'b0;
        do_rise_first = 1'b0;
        do_fall       = 1'b0;
        do_rise_next  = 1'b0;
        do_finish     = 1'b0;
        do_gap_end    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    do_accept = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(CS_LEAD);
                    state_nxt = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tmr_expire) begin
                    do_rise_first = 1'b1;
                    tmr_load      = 1'b1;
                    tmr_val       = TW'(CLK_DIV);
                    state_nxt     = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tmr_expire) begin
                    do_fall   = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = TW'(CLK_DIV);
                    state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (bit_cnt != 6'd0) begin
                        do_rise_next = 1'b1;
                        tmr_val      = TW'(CLK_DIV);
                        state_nxt    = ST_HIGH;
                    end else begin
                        do_finish = 1'b1;
                        tmr_val   = TW'(CS_GAP);
                        state_nxt = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    do_gap_end = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            miso_s1 <= MISO;
            miso_s2 <= miso_s1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shift_tx <= '0;
            shift_rx <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            SCK      <= 1'b0;
            CSEL     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (do_accept) begin
                shift_tx <= tx_aligned;
                shift_rx <= '0;
                bit_cnt  <= n_frame - 6'd1;
                CSEL     <= 1'b0;
                busy     <= 1'b1;
            end
            // First rise carries bit N-1, already on MOSI since accept.
            if (do_rise_first)
                SCK <= 1'b1;
            if (do_fall) begin
                SCK      <= 1'b0;
                shift_rx <= {shift_rx[MAX_BITS-2:0], miso_s2};
            end
            if (do_rise_next) begin
                SCK      <= 1'b1;
                bit_cnt  <= bit_cnt - 6'd1;
                shift_tx <= shift_tx << 1;
            end
            if (do_finish) begin
                CSEL     <= 1'b1;
                shift_tx <= '0;
                rx_data  <= shift_rx;
                done     <= 1'b1;
            end
            if (do_gap_end)
                busy <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
// Directed bench for spi_master_ctrl with a behavioural slave (loopback or
// fixed send data) and a timing model that predicts every output per cycle.
module tb_spi_master_ctrl;

    localparam int CLK_DIV = 8;
    localparam int CS_LEAD = 8;
    localparam int CS_GAP  = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  msg_type = 3'd0;
    logic [3:0]  byte_count = 4'd0;
    logic [47:0] tx_data = '0;
    logic        busy, done, SCK, MOSI, CSEL, MISO;
    logic [47:0] rx_data;

    always #5 CLK = ~CLK;

    spi_master_ctrl #(
        .CLK_DIV(CLK_DIV),
        .CS_LEAD(CS_LEAD),
        .CS_GAP (CS_GAP)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .msg_type   (msg_type),
        .byte_count (byte_count),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .rx_data    (rx_data),
        .SCK        (SCK),
        .MOSI       (MOSI),
        .CSEL       (CSEL),
        .MISO       (MISO)
    );

    // Slave: presents its next bit on each SCK rise, MSB first.
    logic        loopback = 1'b0;
    logic [47:0] slave_data = '0;
    int          slave_n = 16;
    logic [47:0] slave_sreg = '0;
    logic        slave_miso = 1'b0;
    int          sck_rises = 0;
    logic [47:0] mosi_bits = '0;
    int          sck_falls = 0;

    assign MISO = loopback ? MOSI : slave_miso;

    always @(negedge CSEL or posedge SCK) begin
        if (SCK === 1'b1) begin
            slave_miso <= slave_sreg[47];
            slave_sreg <= slave_sreg << 1;
            sck_rises  <= sck_rises + 1;
        end else begin
            slave_sreg <= slave_data << (48 - slave_n);
            sck_rises  <= 0;
        end
    end

    always @(negedge SCK) begin
        mosi_bits <= {mosi_bits[46:0], MOSI};
        sck_falls <= sck_falls + 1;
    end

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          m_active = 1'b0;
    int          m_t0 = 0;
    int          m_n = 16;
    logic [47:0] m_tx = '0;
    logic [47:0] m_rx_frame = '0;
    logic [47:0] m_rx_prev = '0;
    int          last_done_cyc = -1;
    int          done_count = 0;

    function automatic int nbits(input logic [2:0] mt, input logic [3:0] bc);
        case (mt)
            3'b001: return 8;
            3'b010: return 16;
            3'b011: return 24;
            3'b110: return 48;
            3'b111: begin
                if (bc == 0) return 16;
                if (bc > 6) return 48;
                return 8 * int'(bc);
            end
            default: return 16;
        endcase
    endfunction

    function automatic logic [47:0] mask(input int n);
        logic [47:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int frame_end();
        return 1 + CS_LEAD + 2 * m_n * CLK_DIV;
    endfunction

    function automatic bit model_idle(input int c);
        return !m_active || (c - m_t0) >= frame_end() + CS_GAP;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): actual %h, required %h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bounded wait expired at cycle %0d", name, cyc);
    endtask

    // Advance one cycle, update the model with what the DUT sampled at the
    // posedge just passed, then compare all outputs at the negedge.
    task automatic step();
        logic s_start, s_rst;
        logic [2:0] s_mt;
        logic [3:0] s_bc;
        logic [47:0] s_tx;
        int t, e, u, k;
        logic x_sck, x_csel, x_mosi, x_busy, x_done;
        logic [47:0] x_rx;
        s_start = start; s_rst = RST; s_mt = msg_type; s_bc = byte_count; s_tx = tx_data;
        @(negedge CLK);
        cyc++;
        if (!RST || !s_rst) begin
            m_active  = 1'b0;
            m_rx_prev = '0;
        end else if (s_start && model_idle(cyc - 1)) begin
            if (m_active) m_rx_prev = m_rx_frame;
            m_active   = 1'b1;
            m_t0       = cyc - 1;
            m_n        = nbits(s_mt, s_bc);
            m_tx       = s_tx & mask(m_n);
            m_rx_frame = loopback ? m_tx : (slave_data & mask(m_n));
        end
        x_sck = 1'b0; x_csel = 1'b1; x_mosi = 1'b0; x_busy = 1'b0; x_done = 1'b0;
        t = cyc - m_t0;
        e = frame_end();
        x_rx = (m_active && t >= e) ? m_rx_frame : m_rx_prev;
        if (m_active && t > 0 && t < e + CS_GAP) begin
            x_busy = 1'b1;
            if (t < e) begin
                x_csel = 1'b0;
                u = t - 1 - CS_LEAD;
                if (u < 0) begin
                    x_mosi = m_tx[m_n - 1];
                end else begin
                    k = u / CLK_DIV;
                    x_sck  = (k % 2 == 0);
                    x_mosi = m_tx[m_n - 1 - k / 2];
                end
            end else if (t == e) begin
                x_done = 1'b1;
            end
        end
        chk("cycle", 64'({SCK, CSEL, MOSI, busy, done, rx_data}),
            64'({x_sck, x_csel, x_mosi, x_busy, x_done, x_rx}));
        if (done === 1'b1) begin
            done_count++;
            last_done_cyc = cyc;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step();
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("wait_done");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic run_frame(input logic [2:0] mt, input logic [3:0] bc, input logic [47:0] tx,
                             input logic lb, input logic [47:0] sdata,
                             output logic [47:0] rx, output int pulses,
                             output logic [47:0] bits, output int lat);
        msg_type   = mt;
        byte_count = bc;
        tx_data    = tx;
        loopback   = lb;
        slave_data = sdata;
        slave_n    = nbits(mt, bc);
        start      = 1'b1;
        step();
        start      = 1'b0;
        tx_data    = 48'({$urandom, $urandom});
        msg_type   = 3'($urandom);
        byte_count = 4'($urandom);
        wait_done();
        rx     = rx_data;
        pulses = sck_rises;
        bits   = mosi_bits;
        lat    = last_done_cyc - m_t0;
        wait_idle();
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [47:0] rx, bits;
        int pulses, lat, d0, f0, csel_high;

        repeat (3) step();
        chk("reset_state", 64'({SCK, CSEL, MOSI, busy, done, rx_data}), 64'({5'b01000, 48'h0}));
        RST = 1'b1;
        repeat (2) step();

        run_frame(3'b010, 4'd0, 48'hA55A, 1'b0, 48'h3C96, rx, pulses, bits, lat);
        chk("two_rx", 64'(rx), 64'h3C96);
        chk("two_pulses", 64'(pulses), 64'd16);
        chk("two_mosi", 64'(bits[15:0]), 64'hA55A);
        chk("two_latency", 64'(lat), 64'd265);

        run_frame(3'b110, 4'd0, 48'h123456789ABC, 1'b1, 48'h0, rx, pulses, bits, lat);
        chk("six_rx", 64'(rx), 64'h123456789ABC);
        chk("six_pulses", 64'(pulses), 64'd48);

        run_frame(3'b111, 4'd3, 48'hABCDEF, 1'b1, 48'h0, rx, pulses, bits, lat);
        chk("long3_pulses", 64'(pulses), 64'd24);
        chk("long3_mosi", 64'(bits[23:0]), 64'hABCDEF);
        chk("long3_rx", 64'(rx), 64'hABCDEF);

        run_frame(3'b111, 4'd0, 48'h1234, 1'b1, 48'h0, rx, pulses, bits, lat);
        chk("long0_pulses", 64'(pulses), 64'd16);
        chk("long0_rx", 64'(rx), 64'h1234);

        run_frame(3'b111, 4'd9, 48'hFEDCBA987654, 1'b1, 48'h0, rx, pulses, bits, lat);
        chk("long9_pulses", 64'(pulses), 64'd48);

        run_frame(3'b001, 4'd0, 48'h0, 1'b0, 48'h5A, rx, pulses, bits, lat);
        chk("one_rx", 64'(rx), 64'h5A);
        chk("one_pulses", 64'(pulses), 64'd8);

        run_frame(3'b001, 4'd0, 48'hFFFFFF0000A6, 1'b1, 48'h0, rx, pulses, bits, lat);
        chk("one_upper_dropped", 64'(rx), 64'hA6);

        run_frame(3'b100, 4'd0, 48'h00C3, 1'b1, 48'h0, rx, pulses, bits, lat);
        chk("other_code_pulses", 64'(pulses), 64'd16);

        // start held through the whole frame, dropped during the gap
        d0 = done_count;
        msg_type = 3'b001; tx_data = 48'h3C; loopback = 1'b1;
        start = 1'b1;
        wait_done();
        step();
        start = 1'b0;
        wait_idle();
        repeat (CS_GAP + 4) step();
        chk("held_one_frame", 64'(done_count - d0), 64'd1);

        // back-to-back: second start in the first cycle busy is low
        msg_type = 3'b001; tx_data = 48'h81; loopback = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        csel_high = 1;
        for (int i = 0; i < 100 && busy === 1'b1; i++) begin
            step();
            if (CSEL === 1'b1) csel_high++;
        end
        tx_data = 48'h7E;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_csel_high", 64'(csel_high), 64'd9);
        chk("b2b_accepted", 64'({busy, CSEL}), 64'b10);
        wait_done();
        chk("b2b_rx", 64'(rx_data), 64'h7E);
        wait_idle();
        step();

        // asynchronous reset after the 5th SCK fall
        f0 = sck_falls;
        msg_type = 3'b010; tx_data = 48'hFFFF; loopback = 1'b0; slave_data = 48'hFFFF; slave_n = 16;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 1000 && (sck_falls - f0) < 5; i++) step();
        chk("rst_fall_count", 64'(sck_falls - f0), 64'd5);
        #2 RST = 1'b0;
        #1;
        chk("rst_async", 64'({SCK, CSEL, busy, done, rx_data}), 64'({4'b0100, 48'h0}));
        d0 = done_count;
        repeat (3) step();
        RST = 1'b1;
        repeat (3) step();
        chk("rst_no_done", 64'(done_count - d0), 64'd0);
        run_frame(3'b001, 4'd0, 48'h00FF, 1'b0, 48'hC3, rx, pulses, bits, lat);
        chk("post_rst_rx", 64'(rx), 64'hC3);
        chk("post_rst_mosi", 64'(bits[7:0]), 64'hFF);
        chk("post_rst_pulses", 64'(pulses), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
# spi_master_ctrl

Host-side SPI master that initiates transfers to the peripheral-side SPI slave on the same board. Drives CSEL, SCK and MOSI and captures MISO full-duplex, MSB first, for 1 to 6 byte frames. Frame lengths use the same message-type encoding the slave uses. Provides a start/busy/done handshake toward the local command logic.

## Interface
- CLK_DIV, default 8: SCK half-period in CLK cycles; legal range ≥6.
- CS_LEAD, default 8: cycles from CSEL fall to the first SCK rise; legal range ≥4.
- CS_GAP, default 8: minimum cycles CSEL stays high after a frame before busy drops; legal range ≥1.
- CLK  in  1: system clock; one clock domain.
- RST  in  1: asynchronous, active-low reset.
- start  in  1: request a frame; sampled only in IDLE.
- msg_type  in  3: frame length code.
- byte_count  in  4: byte count used when msg_type=LONG.
- tx_data  in  48: frame data, right-aligned; bit N-1 is sent first.
- busy  out  1: high from the accept cycle until the CS_GAP period ends.
- done  out  1: one-cycle pulse when rx_data is valid.
- rx_data  out  48: received frame, right-aligned, zero-extended.
- SCK  out  1: serial clock, idles low.
- MOSI  out  1: master data out.
- CSEL  out  1: chip select, active low.
- MISO  in  1: slave data in, synchronised by two flops internally.

## Operation
- Frame length N in bits, set by msg_type:
  - ONE_BY 001: 8.
  - STD_TWO_BY 010: 16.
  - THREE_BY 011: 24.
  - SIX_BY 110: 48.
  - LONG 111: 8·byte_count. byte_count 0 gives 16; byte_count >6 gives 48.
  - Any other code: 16.
- msg_type, byte_count and tx_data are latched on accept. Later input changes have no effect on the frame in progress.
- States:
  - IDLE: start=1 is accepted. Load shift_tx = tx_data << (48-N), clear shift_rx, load bit counter = N-1, go to LEAD.
  - LEAD: CSEL=0, MOSI = bit N-1. After CS_LEAD cycles drive SCK=1 and go to HIGH.
  - HIGH: after CLK_DIV cycles drive SCK=0, shift the synchronised MISO into shift_rx LSB, go to LOW.
  - LOW: after CLK_DIV cycles, if counter≠0: decrement, shift shift_tx left, present the next bit on MOSI, drive SCK=1, go to HIGH. If counter=0: CSEL=1, MOSI=0, rx_data = shift_rx, pulse done, go to GAP.
  - GAP: after CS_GAP cycles, busy=0 and go to IDLE.
- Bit update rules:
  - MOSI changes only on SCK rising edges, because the slave samples MOSI on falling edges.
  - MISO is sampled at SCK falling edges, because the slave updates MISO on rising edges.
- start while busy=1 is ignored and not queued.
- rx_data holds its value until the next done pulse.

## Timing
- Reset values: SCK=0, CSEL=1, MOSI=0, busy=0, done=0, rx_data=0, state IDLE. Reset is asynchronous and takes effect at once.
- T0 is the cycle in which start is sampled high in IDLE.
  - T0+1: busy=1, CSEL=0, MOSI = bit N-1.
  - First SCK rise: T0+1+CS_LEAD.
  - Falling edge of bit k (k=1..N): T0+1+CS_LEAD+(2k-1)·CLK_DIV.
  - CSEL rises, done pulses and rx_data updates: T0+1+CS_LEAD+2N·CLK_DIV.
  - busy falls: CS_GAP cycles after that.
- The earliest next accept is in the cycle after busy falls.
- Reset mid-frame: all outputs return to reset values immediately, with no done pulse and no partial rx_data. The first start after reset releases behaves normally.
- CLK_DIV ≥6 covers the slave's 3-flop SCK synchroniser, its MISO register delay and this block's 2-flop MISO synchroniser.

## Structure
- Package spi_pkg holds:
  - msg-type constants NO_BY, ONE_BY, STD_TWO_BY, THREE_BY, SIX_BY, LONG;
  - MAX_BITS=48;
  - function frame_bits(msg_type, byte_count) returning N.
- The slave shares spi_pkg.
- One sub-module, spi_half_period_timer: a down-counter that is loaded with CLK_DIV, CS_LEAD or CS_GAP and raises a one-cycle expire pulse. The FSM, shift registers and MISO synchroniser stay in the top module.

## Test plan
- STD_TWO_BY, tx_data=0xA55A, slave model returns 0x3C96. Expected:
  - MOSI sequence on falling edges is 1010_0101_0101_1010;
  - exactly 16 SCK pulses;
  - with defaults, done at T0+265 and rx_data=0x3C96.
- SIX_BY, tx_data=0x123456789ABC, MISO looped back from MOSI -> 48 pulses, rx_data=0x123456789ABC.
- LONG variants:
  - byte_count=3, tx_data=0xABCDEF -> 24 pulses, bits from 0xABCDEF.
  - byte_count=0 -> 16 pulses.
  - byte_count=9 -> 48 pulses.
  - ONE_BY -> 8 pulses.
- Handshake:
  - start held high throughout a frame -> exactly one frame runs.
  - Second start issued the cycle after busy falls -> accepted; CSEL was high for at least CS_GAP cycles.
- RST low after the 5th falling edge -> SCK=0, CSEL=1, busy=0 with no clock edge needed. No done pulse. rx_data=0. The next 0x00FF ONE_BY frame completes correctly.
- Against the peripheral slave RTL with CLK_DIV=6:
  - 16-bit write: the slave's received_data equals tx_data and its received pulse fires.
  - Slave SEND of 0x5A: rx_data=0x5A.
